// File: rtl/spi_cmd_pkg.sv
// Shared constants and FSM encoding for the SPI read-command scheduler.
package spi_cmd_pkg;

  localparam logic [3:0] OPC_READ_BURST  = 4'hF;
  localparam logic [3:0] OPC_READ_STATUS = 4'h7;
  localparam logic [7:0] STATUS_TAG      = 8'hA5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    CAPT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from ptr with wrap, reports the winner
// and the pointer value that should follow a grant.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic             enable,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [PTR_W-1:0] winner,
  output logic [PTR_W-1:0] ptr_next
);

  int         idx;
  logic       found;
  logic [PTR_W-1:0] sel;

  always_comb begin
    gnt      = '0;
    winner   = '0;
    ptr_next = ptr;
    found    = 1'b0;
    idx      = 0;
    sel      = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = PTR_W'(idx);
      if (enable && !found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        winner   = sel;
        ptr_next = (idx == NREQ - 1) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

endmodule

// File: rtl/spi_rd_sched.sv
// SPI command scheduler: decodes command words, prefetches buffer words for
// the shifter, and shares the buffer port with round-robin internal writers.
module spi_rd_sched
  import spi_cmd_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int NREQ        = 2,
  parameter int BURST_WORDS = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cs,
  input  logic                     i_rx_valid,
  input  logic [15:0]              i_rx_word,
  output logic [15:0]              o_tx_word,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ack,
  input  logic [NREQ-1:0]          i_wr_req,
  input  logic [NREQ*ADDR_W-1:0]   i_wr_addr,
  input  logic [NREQ*16-1:0]       i_wr_data,
  output logic [NREQ-1:0]          o_wr_gnt,
  output logic                     o_mem_en,
  output logic                     o_mem_we,
  output logic [ADDR_W-1:0]        o_mem_addr,
  output logic [15:0]              o_mem_wdata,
  input  logic [15:0]              i_mem_rdata,
  output logic [7:0]               o_err_cnt
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(BURST_WORDS) + 1;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              burst_reg, burst_next;
  logic [15:0]       tx_word_reg, tx_word_next;
  logic              tx_valid_reg, tx_valid_next;
  logic [7:0]        err_reg, err_next;
  logic [PTR_W-1:0]  ptr_reg, ptr_next, winner;
  logic [NREQ-1:0]   gnt;
  logic              wr_enable;
  logic              cmd_strobe;
  logic [3:0]        opcode;
  logic [11:0]       cmd_arg;
  logic              unused_cmd_arg;

  logic [ADDR_W-1:0] req_addr [NREQ];
  logic [15:0]       req_data [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign req_addr[gi] = i_wr_addr[gi*ADDR_W +: ADDR_W];
      assign req_data[gi] = i_wr_data[gi*16 +: 16];
    end
  endgenerate

  assign cmd_strobe     = i_rx_valid & ~i_cs;
  assign opcode         = i_rx_word[15:12];
  assign cmd_arg        = i_rx_word[11:0];
  assign unused_cmd_arg = ^cmd_arg;

  // A pending read owns the port for its single FETCH cycle.
  assign wr_enable = (state_reg != FETCH) && !i_rst;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_wr_arb (
    .req      (i_wr_req),
    .enable   (wr_enable),
    .ptr      (ptr_reg),
    .gnt      (gnt),
    .winner   (winner),
    .ptr_next (ptr_next)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      cnt_reg      <= '0;
      burst_reg    <= 1'b0;
      tx_word_reg  <= '0;
      tx_valid_reg <= 1'b0;
      err_reg      <= '0;
      ptr_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      cnt_reg      <= cnt_next;
      burst_reg    <= burst_next;
      tx_word_reg  <= tx_word_next;
      tx_valid_reg <= tx_valid_next;
      err_reg      <= err_next;
      ptr_reg      <= ptr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    cnt_next      = cnt_reg;
    burst_next    = burst_reg;
    tx_word_next  = tx_word_reg;
    tx_valid_next = tx_valid_reg;
    err_next      = err_reg;

    if (i_cs) begin
      // Abort: any read already on the port finishes there, but CAPT never runs.
      state_next    = IDLE;
      tx_valid_next = 1'b0;
      burst_next    = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_strobe) begin
            if (opcode == OPC_READ_BURST) begin
              addr_next  = cmd_arg[ADDR_W-1:0];
              cnt_next   = '0;
              burst_next = 1'b1;
              state_next = FETCH;
            end else if (opcode == OPC_READ_STATUS) begin
              tx_word_next  = {STATUS_TAG, err_reg};
              tx_valid_next = 1'b1;
              burst_next    = 1'b0;
              state_next    = HOLD;
            end else begin
              err_next = sat_inc8(err_reg);
            end
          end
        end
        FETCH: state_next = CAPT;
        CAPT: begin
          tx_word_next  = i_mem_rdata;
          tx_valid_next = 1'b1;
          state_next    = HOLD;
        end
        HOLD: begin
          if (i_tx_ack && tx_valid_reg) begin
            tx_valid_next = 1'b0;
            if (burst_reg && (cnt_reg < CNT_W'(BURST_WORDS - 1))) begin
              cnt_next   = cnt_reg + CNT_W'(1);
              addr_next  = addr_reg + ADDR_W'(1);
              state_next = FETCH;
            end else begin
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase

      // Words arriving mid-transaction (including readout dummies) are rejected.
      if (cmd_strobe && (state_reg != IDLE)) err_next = sat_inc8(err_reg);
    end
  end

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (state_reg == FETCH) begin
      o_mem_en   = 1'b1;
      o_mem_addr = addr_reg;
    end else if (|gnt) begin
      o_mem_en    = 1'b1;
      o_mem_we    = 1'b1;
      o_mem_addr  = req_addr[winner];
      o_mem_wdata = req_data[winner];
    end
  end

  assign o_wr_gnt   = gnt;
  assign o_tx_word  = tx_word_reg;
  assign o_tx_valid = tx_valid_reg;
  assign o_err_cnt  = err_reg;

endmodule

// File: tb/tb_spi_rd_sched.sv
// Bench for spi_rd_sched: command table, hand-written corner sequences and a
// randomized run against a transaction-level reference model.
module tb_spi_rd_sched;

  localparam int ADDR_W = 8;
  localparam int NREQ   = 2;
  localparam int BW     = 4;

  logic                   clk = 1'b0;
  logic                   rst, cs, rx_valid, ack;
  logic [15:0]            rx_word;
  logic [15:0]            o_tx_word;
  logic                   o_tx_valid;
  logic [NREQ-1:0]        wr_req;
  logic [NREQ*ADDR_W-1:0] wr_addr;
  logic [NREQ*16-1:0]     wr_data;
  logic [NREQ-1:0]        o_wr_gnt;
  logic                   o_mem_en, o_mem_we;
  logic [ADDR_W-1:0]      o_mem_addr;
  logic [15:0]            o_mem_wdata;
  logic [15:0]            rdata;
  logic [7:0]             o_err_cnt;

  logic [15:0] mem     [256];
  logic [15:0] ref_mem [256];
  logic        mem_init;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spi_rd_sched #(.ADDR_W(ADDR_W), .NREQ(NREQ), .BURST_WORDS(BW)) dut (
    .i_clk(clk), .i_rst(rst), .i_cs(cs), .i_rx_valid(rx_valid), .i_rx_word(rx_word),
    .o_tx_word(o_tx_word), .o_tx_valid(o_tx_valid), .i_tx_ack(ack),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_gnt(o_wr_gnt),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(rdata), .o_err_cnt(o_err_cnt)
  );

  function automatic logic [15:0] init_val(input int a);
    logic [7:0] b;
    b = a[7:0];
    if (b >= 8'd1 && b <= 8'd4) return 16'h1111 * 16'(b);
    return {b, ~b};
  endfunction

  // Single-port buffer with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (o_mem_en) begin
      if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
      else          rdata <= mem[o_mem_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_init = 1'b1; cs = 1'b0; rx_valid = 1'b0; rx_word = '0; ack = 1'b0;
    wr_req = '0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    repeat (2) cyc();
    rst = 1'b0; mem_init = 1'b0;
  endtask

  task automatic send_cmd(input logic [15:0] w);
    rx_word = w; rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    cyc();
    ack = 1'b0;
  endtask

  // n counts the cycle we are in as 1; returns 99 if the word never shows up.
  task automatic wait_valid(output int n);
    n = 1;
    while (!o_tx_valid && n < 12) begin
      cyc();
      n++;
    end
    if (!o_tx_valid) n = 99;
  endtask

  task automatic run_burst(input logic [7:0] base);
    int n;
    logic [7:0] a;
    send_cmd({8'hF0, base});
    for (int k = 0; k < BW; k++) begin
      a = base + 8'(k);
      chk("burst_fetch", {o_mem_en, o_mem_we, o_mem_addr}, {1'b1, 1'b0, a});
      wait_valid(n);
      chk("burst_lat", n, 3);
      chk("burst_word", o_tx_word, init_val(a));
      do_ack();
    end
    chk("burst_end_valid", o_tx_valid, 0);
    chk("burst_end_idle", o_mem_en, 0);
    cyc();
    chk("burst_end_idle2", o_mem_en, 0);
  endtask

  typedef struct {
    logic [15:0] cmd;
    bit          has_data;
    int          lat;
    logic [15:0] word;
    logic [7:0]  err;
  } vec_t;

  vec_t vecs [10];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n;
    int nwords;

    vecs[0] = '{16'hF001, 1'b1, 3, 16'h1111, 8'd0};
    vecs[1] = '{16'h7001, 1'b1, 1, 16'hA500, 8'd0};
    vecs[2] = '{16'h3000, 1'b0, 0, 16'h0000, 8'd1};
    vecs[3] = '{16'h7001, 1'b1, 1, 16'hA501, 8'd1};
    vecs[4] = '{16'h0000, 1'b0, 0, 16'h0000, 8'd2};
    vecs[5] = '{16'hE00F, 1'b0, 0, 16'h0000, 8'd3};
    vecs[6] = '{16'hF0FF, 1'b1, 3, 16'hFF00, 8'd3};
    vecs[7] = '{16'h8001, 1'b0, 0, 16'h0000, 8'd4};
    vecs[8] = '{16'h7FFF, 1'b1, 1, 16'hA504, 8'd4};
    vecs[9] = '{16'hF004, 1'b1, 3, 16'h4444, 8'd4};

    // Reset state
    do_reset();
    chk("rst_tx_word", o_tx_word, 0);
    chk("rst_tx_valid", o_tx_valid, 0);
    chk("rst_gnt", o_wr_gnt, 0);
    chk("rst_mem", {o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata}, 0);
    chk("rst_err", o_err_cnt, 0);

    // Command table
    for (int v = 0; v < 10; v++) begin
      send_cmd(vecs[v].cmd);
      if (vecs[v].has_data) begin
        wait_valid(n);
        chk("vec_lat", n, vecs[v].lat);
        chk("vec_word", o_tx_word, vecs[v].word);
        nwords = (vecs[v].lat == 3) ? BW : 1;
        for (int k = 0; k < nwords; k++) begin
          if (k > 0) wait_valid(n);
          do_ack();
        end
      end
      repeat (3) cyc();
      chk("vec_quiet", o_tx_valid, 0);
      chk("vec_err", o_err_cnt, vecs[v].err);
    end

    // Full bursts, including address wrap FE, FF, 00, 01
    do_reset();
    run_burst(8'h01);
    run_burst(8'hFE);
    chk("burst_err", o_err_cnt, 0);

    // Dummy word during HOLD is rejected, readout continues
    send_cmd(16'h7001);
    chk("dummy_status_valid", o_tx_valid, 1);
    send_cmd(16'h0000);
    chk("dummy_err", o_err_cnt, 1);
    chk("dummy_still_valid", o_tx_valid, 1);
    do_ack();

    // Ack while nothing is valid is ignored
    send_cmd(16'hF001);
    do_ack();
    wait_valid(n);
    chk("spur_lat", n, 2);
    chk("spur_word0", o_tx_word, 16'h1111);
    do_ack();
    wait_valid(n);
    chk("spur_word1", o_tx_word, 16'h2222);
    cs = 1'b1; cyc(); cs = 1'b0; cyc();

    // CS abort during HOLD after 2 words, then restart at word 0
    do_reset();
    send_cmd(16'hF001);
    for (int k = 0; k < 2; k++) begin
      wait_valid(n);
      do_ack();
    end
    wait_valid(n);
    chk("abort_hold_word", o_tx_word, 16'h3333);
    cs = 1'b1;
    cyc();
    chk("abort_hold_valid", o_tx_valid, 0);
    chk("abort_hold_idle", o_mem_en, 0);
    cs = 1'b0;
    cyc();
    run_burst(8'h01);

    // CS abort during FETCH: read still hits the port, data discarded
    send_cmd(16'hF002);
    cs = 1'b1;
    #1;
    chk("abort_fetch_port", {o_mem_en, o_mem_we, o_mem_addr}, {1'b1, 1'b0, 8'h02});
    cyc();
    chk("abort_fetch_idle", o_mem_en, 0);
    repeat (3) cyc();
    chk("abort_fetch_valid", o_tx_valid, 0);
    cs = 1'b0;
    cyc();
    chk("abort_err", o_err_cnt, 0);

    // Round-robin writes with a colliding burst fetch
    do_reset();
    wr_addr = {8'hC1, 8'hC0};
    wr_data = {16'hBEEF, 16'hCAFE};
    wr_req  = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_gnt", o_wr_gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_port", {o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata},
          (k % 2 == 0) ? {1'b1, 1'b1, 8'hC0, 16'hCAFE} : {1'b1, 1'b1, 8'hC1, 16'hBEEF});
      cyc();
    end
    chk("rr_mem0", mem[8'hC0], 16'hCAFE);
    chk("rr_mem1", mem[8'hC1], 16'hBEEF);
    rx_word = 16'hF020; rx_valid = 1'b1;
    #1;
    chk("col_cmd_gnt", o_wr_gnt, 2'b01);
    cyc();
    rx_valid = 1'b0;
    #1;
    chk("col_fetch_gnt", o_wr_gnt, 2'b00);
    chk("col_fetch_port", {o_mem_en, o_mem_we, o_mem_addr}, {1'b1, 1'b0, 8'h20});
    cyc();
    #1;
    chk("col_after_gnt", o_wr_gnt, 2'b10);
    cyc();
    wr_req = '0;
    cs = 1'b1; cyc(); cs = 1'b0; cyc();

    // Error counter saturation
    do_reset();
    rx_word = 16'h1234; rx_valid = 1'b1;
    for (int i = 0; i < 270; i++) begin
      cyc();
      if (i == 253) chk("sat_254", o_err_cnt, 8'hFE);
      if (i == 254) chk("sat_255", o_err_cnt, 8'hFF);
    end
    rx_valid = 1'b0;
    cyc();
    chk("sat_270", o_err_cnt, 8'hFF);
    send_cmd(16'h7001);
    chk("sat_status", {o_tx_valid, o_tx_word}, {1'b1, 16'hA5FF});
    do_ack();

    // Reset mid-operation
    do_reset();
    send_cmd(16'h3000);
    send_cmd(16'hF001);
    wait_valid(n);
    chk("midrst_pre", {o_tx_valid, o_err_cnt}, {1'b1, 8'd1});
    rst = 1'b1;
    cyc();
    chk("midrst_out", {o_tx_valid, o_tx_word, o_err_cnt, o_mem_en, o_wr_gnt}, 0);
    rst = 1'b0;

    // Randomized run against a transaction-level model
    do_reset();
    begin : rand_phase
      int          ptr_m, host_st, gap, kw, next_fetch, valid_at, w, mism;
      bit          pend  [NREQ];
      logic [7:0]  paddr [NREQ];
      logic [15:0] pdata [NREQ];
      logic [7:0]  base, fa;
      bit          exp_v, fetch_e;
      logic [15:0] exp_wd;
      logic [NREQ-1:0] exp_g;
      ptr_m = 0; host_st = 0; gap = 0; kw = 0; next_fetch = -1; valid_at = 0; base = '0;
      for (int k = 0; k < NREQ; k++) begin
        pend[k] = 1'b0; paddr[k] = '0; pdata[k] = '0;
      end
      for (int c = 0; c < 4000; c++) begin
        for (int k = 0; k < NREQ; k++) begin
          if (!pend[k] && $urandom_range(2) == 0) begin
            pend[k]  = 1'b1;
            paddr[k] = 8'h80 | 8'($urandom_range(127));
            pdata[k] = 16'($urandom);
          end
          wr_req[k]          = pend[k];
          wr_addr[k*8 +: 8]  = paddr[k];
          wr_data[k*16 +: 16] = pdata[k];
        end
        exp_v   = (host_st == 1) && (c >= valid_at);
        fetch_e = (host_st == 1) && (c == next_fetch);
        fa      = base + 8'(kw);
        exp_wd  = init_val(fa);
        rx_valid = 1'b0;
        ack      = 1'b0;
        if (host_st == 0) begin
          if (gap == 0) begin
            base = 8'($urandom_range(124));
            rx_word = {8'hF0, base};
            rx_valid = 1'b1;
            host_st = 1; kw = 0; next_fetch = c + 1; valid_at = c + 3;
          end else begin
            gap--;
          end
        end else if (exp_v && $urandom_range(1) == 1) begin
          ack = 1'b1;
          kw++;
          if (kw < BW) begin
            next_fetch = c + 1; valid_at = c + 3;
          end else begin
            host_st = 0; gap = $urandom_range(3);
          end
        end
        w = -1;
        if (!fetch_e) begin
          for (int i = 0; i < NREQ; i++) begin
            int j;
            j = (ptr_m + i) % NREQ;
            if (w < 0 && pend[j]) w = j;
          end
        end
        exp_g = (w >= 0) ? NREQ'(1 << w) : '0;
        #1;
        chk("rand_valid", o_tx_valid, exp_v);
        if (exp_v) chk("rand_word", o_tx_word, exp_wd);
        chk("rand_gnt", o_wr_gnt, exp_g);
        if (fetch_e) begin
          chk("rand_fetch", {o_mem_en, o_mem_we, o_mem_addr}, {1'b1, 1'b0, fa});
        end else if (w >= 0) begin
          chk("rand_wr", {o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata},
              {1'b1, 1'b1, paddr[w], pdata[w]});
          ref_mem[paddr[w]] = pdata[w];
          pend[w] = 1'b0;
          ptr_m = (w + 1) % NREQ;
        end else begin
          chk("rand_quiet", o_mem_en, 0);
        end
        cyc();
      end
      wr_req = '0; rx_valid = 1'b0; ack = 1'b0;
      cyc();
      mism = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
      chk("rand_mem_diffs", mism, 0);
      chk("rand_err", o_err_cnt, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_rd_sched.md
Name: spi_rd_sched

Overview:
- Command scheduler between the SPI slave shifter and a shared single-port word buffer.
- Decodes each 16-bit command word received over SPI.
- For read commands, prefetches words from the buffer and hands them to the shifter one 16-bit frame at a time.
- Shares the buffer port among NREQ internal writers with round-robin arbitration; SPI reads always take priority.

Parameters:
ADDR_W, 8, buffer address width
NREQ, 2, number of internal write requesters
BURST_WORDS, 4, words returned per READ_BURST (4 x 16 = 64 bits)

Ports:
i_clk  in  1  system clock (48 MHz)
i_rst  in  1  synchronous active-high reset
i_cs  in  1  SPI chip select, active low, already synchronised to i_clk
i_rx_valid  in  1  one-cycle strobe: shifter has received a complete 16-bit word
i_rx_word  in  16  received word, valid with i_rx_valid
o_tx_word  out  16  next word for the shifter to send
o_tx_valid  out  1  o_tx_word holds a valid, unconsumed word
i_tx_ack  in  1  one-cycle strobe: shifter has loaded o_tx_word into its shift register
i_wr_req  in  NREQ  per-requester write request, held until granted
i_wr_addr  in  NREQ*ADDR_W  per-requester address; requester k uses slice k
i_wr_data  in  NREQ*16  per-requester write data; requester k uses slice k
o_wr_gnt  out  NREQ  one-hot, one-cycle write grant
o_mem_en  out  1  buffer port enable
o_mem_we  out  1  buffer write enable
o_mem_addr  out  ADDR_W  buffer address
o_mem_wdata  out  16  buffer write data
i_mem_rdata  in  16  buffer read data, valid 1 cycle after a read enable
o_err_cnt  out  8  saturating count of rejected commands

Behaviour:
- Reset: all outputs 0, FSM in IDLE, round-robin pointer at requester 0.
- Command decode on i_rx_valid while i_cs=0:
  - [15:12]=4'hF: READ_BURST, base address = i_rx_word[ADDR_W-1:0].
  - [15:12]=4'h7: READ_STATUS.
  - Any other opcode: ignored, o_err_cnt += 1.
- FSM states:
  - IDLE: on READ_BURST, load addr <= base and cnt <= 0, go to FETCH. On READ_STATUS, drive o_tx_word = {8'hA5, o_err_cnt}, assert o_tx_valid, go to HOLD.
  - FETCH: o_mem_en=1, o_mem_we=0, o_mem_addr=addr for exactly 1 cycle, then go to CAPT.
  - CAPT: o_tx_word <= i_mem_rdata, o_tx_valid <= 1, go to HOLD.
  - HOLD: wait for i_tx_ack. On ack, clear o_tx_valid.
    - If this was a burst and cnt < BURST_WORDS-1: cnt += 1, addr += 1, go to FETCH.
    - Otherwise go to IDLE.
- Latency:
  - Command strobe to o_tx_valid: 3 cycles for READ_BURST, 1 cycle for READ_STATUS.
  - Ack to next o_tx_valid: 3 cycles.
- Address arithmetic is modulo 2^ADDR_W; base 8'hFF continues at 8'h00.
- i_rx_valid in any state other than IDLE: the command is not executed, o_err_cnt += 1. Dummy words clocked in during a readout are not commands and arrive only while in HOLD, so they count too.
- i_cs rising at any point (CS abort): return to IDLE next cycle, clear o_tx_valid, leave the write pointer unchanged. If a read is pending in FETCH it still completes on the port, but its data is discarded.
- i_tx_ack while o_tx_valid=0: ignored.
- o_err_cnt saturates at 8'hFF and is cleared only by i_rst.
- Write arbitration:
  - Writes may use the port in any cycle in which the FSM is not in FETCH.
  - Winner is the first set bit of i_wr_req searching upward from the pointer, with wrap.
  - Grant cycle: o_mem_en=1, o_mem_we=1, address/data taken from the winner's slice, o_wr_gnt one-hot for that cycle.
  - Pointer then moves to winner+1 (mod NREQ).
- FETCH in the same cycle as a pending write: the read wins, o_wr_gnt=0, the request stays pending.
- i_rst mid-operation: everything returns to reset values on the next clock edge.

Decomposition:
- Package spi_cmd_pkg: opcode constants OPC_READ_BURST=4'hF, OPC_READ_STATUS=4'h7, STATUS_TAG=8'hA5, and the FSM state encoding (IDLE, FETCH, CAPT, HOLD).
- Sub-module rr_arbiter: parameter NREQ; inputs req and enable; outputs one-hot gnt and the pointer update. It is instantiated once for the write path.

Test Plan:
- Preload buffer 0x01..0x04 = 16'h1111, 2222, 3333, 4444; send 16'hF001; ack each word -> o_tx_word sequence 1111, 2222, 3333, 4444, then IDLE; first o_tx_valid 3 cycles after the strobe.
- Send 16'hF0FE with BURST_WORDS=4 -> reads addresses FE, FF, 00, 01 in that order.
- Send 16'h7001 -> o_tx_word=16'hA500 one cycle later; then send 16'h3000 and repeat 7001 -> 16'hA501.
- Raise i_cs after 2 of 4 words -> o_tx_valid=0 and IDLE within 1 cycle; a new F001 after CS falls again restarts at word 0.
- Hold both i_wr_req bits high continuously with no SPI traffic -> grants alternate 01, 10, 01, 10; when a burst fetch coincides, o_wr_gnt=0 that cycle and the other requester wins next.
- Send 270 invalid opcodes -> o_err_cnt stops at 8'hFF.
